// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready handshake on both sides.
// Single-cycle ops complete straight into DONE; MUL runs a shift-add
// sequence for WIDTH cycles in BUSY before presenting the full product.
module alu_pipe #(
  parameter int WIDTH  = 4,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic [3:0]       FLAGS
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic [WIDTH-1:0]       result_r;
  logic [WIDTH-1:0]       result_hi_r;
  logic [3:0]             flags_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [2*WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]       mplier_r;
  logic [2*WIDTH-1:0]     prod_r;
  logic                   accept_s;
  logic                   is_mul_s;
  logic                   mul_last_s;
  logic [2*WIDTH-1:0]     mul_sum_s;
  logic [WIDTH+3:0]       alu_out_s;

  // Flags word {N,V,C,Z}; N and Z look only at the low result half.
  function automatic logic [3:0] flags_of(input logic [WIDTH-1:0] r,
                                          input logic v,
                                          input logic c);
    return {r[WIDTH-1], v, c, (r == {WIDTH{1'b0}})};
  endfunction

  // Single-cycle operations; returns {flags, result}. Opcode 111 only
  // reaches here when multiply is disabled, and then behaves as ADD.
  function automatic logic [WIDTH+3:0] alu_calc(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    ext = {(WIDTH+1){1'b0}};
    r   = {WIDTH{1'b0}};
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      3'b001: begin
        ext = {1'b0, a} - {1'b0, b};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: begin
        if (32'(b) >= 32'(WIDTH)) r = {WIDTH{1'b0}};
        else                      r = a << b;
      end
      3'b110: begin
        if (32'(b) >= 32'(WIDTH)) r = {WIDTH{1'b0}};
        else                      r = a >> b;
      end
      default: begin
        ext = {1'b0, a} + {1'b0, b};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
    return {flags_of(r, v, c), r};
  endfunction

  assign accept_s   = in_valid && (state_r == IDLE);
  assign is_mul_s   = (MUL_EN != 0) && (OPCODE == 3'b111);
  assign mul_last_s = (cnt_r == CNT_W'(WIDTH - 1));
  assign mul_sum_s  = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
  assign alu_out_s  = alu_calc(OPCODE, OP1, OP2);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign RESULT    = result_r;
  assign RESULT_HI = result_hi_r;
  assign FLAGS     = flags_r;

  // Next-state decode; the handoff out of DONE never accepts in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = is_mul_s ? BUSY : DONE;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        if (mul_last_s) state_nxt_s = DONE;
        else            state_nxt_s = BUSY;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus registered handshake outputs; reset wins over accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Datapath: capture on accept, iterate the multiplier, hold results in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      flags_r     <= 4'b0000;
      cnt_r       <= {CNT_W{1'b0}};
      mcand_r     <= {(2*WIDTH){1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      prod_r      <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (is_mul_s) begin
              mcand_r  <= {{WIDTH{1'b0}}, OP1};
              mplier_r <= OP2;
              prod_r   <= {(2*WIDTH){1'b0}};
              cnt_r    <= {CNT_W{1'b0}};
            end else begin
              result_r    <= alu_out_s[WIDTH-1:0];
              result_hi_r <= {WIDTH{1'b0}};
              flags_r     <= alu_out_s[WIDTH+3:WIDTH];
            end
          end
        end
        BUSY: begin
          prod_r   <= mul_sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          if (mul_last_s) begin
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= mul_sum_s[WIDTH-1:0];
            result_hi_r <= mul_sum_s[2*WIDTH-1:WIDTH];
            flags_r     <= flags_of(mul_sum_s[WIDTH-1:0], 1'b0,
                                    |mul_sum_s[2*WIDTH-1:WIDTH]);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

endmodule
